// File: rtl/vol_recording_ctrl_pkg.sv
// Shared definitions for the volume-acquisition sequencer, the line writer and the PIO map.
// Contents:
//   ALINE_W_DEF / BSCAN_W_DEF / MISS_W_DEF  default widths of the index and miss counters
//   vol_state_e                             sequencer state encoding (visible to software)
package vol_recording_ctrl_pkg;

  localparam int unsigned ALINE_W_DEF = 12;
  localparam int unsigned BSCAN_W_DEF = 12;
  localparam int unsigned MISS_W_DEF  = 16;

  // Encoding is fixed: the PIO map exposes it.
  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWaitTrig  = 2'd1,
    StWriteLine = 2'd2,
    StDone      = 2'd3
  } vol_state_e;

endpackage

// File: rtl/vol_recording_ctrl_rise_edge_det.sv
// Rising-edge detector for an already-synchronised level.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset (previous sample clears to 0)
//   i_sig    level input
//   o_rise   high for the cycle in which i_sig is 1 and its previous sample was 0
module vol_recording_ctrl_rise_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sig_d <= 1'b0;
    end else begin
      r_sig_d <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_sig_d;

endmodule

// File: rtl/vol_recording_ctrl.sv
// Volume-acquisition sequencer: counts sweep triggers into B-scans and volumes, requests one
// line write per accepted A-line, flags triggers that arrive while a line is in flight, and
// holds o_vol_recording_done once the programmed volume is complete.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   i_start / i_abort       1-cycle host pulses (abort wins over start)
//   i_n_alines / i_n_bscans volume geometry, latched on start
//   i_aline_trig            sweep trigger level; rising edge = new A-line
//   i_aline_done            line writer finished the current line
//   o_aline_start           1-cycle request to the line writer
//   o_aline_idx/o_bscan_idx current line / B-scan index
//   o_busy                  high while acquiring (WAIT_TRIG or WRITE_LINE)
//   o_vol_recording_done    level, from volume completion until next start
//   o_missed_trig/o_missed_cnt sticky miss flag and saturating miss count
module vol_recording_ctrl
  import vol_recording_ctrl_pkg::*;
#(
  parameter int unsigned ALINE_W = ALINE_W_DEF,
  parameter int unsigned BSCAN_W = BSCAN_W_DEF,
  parameter int unsigned MISS_W  = MISS_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [ALINE_W-1:0] i_n_alines,
  input  logic [BSCAN_W-1:0] i_n_bscans,
  input  logic               i_aline_trig,
  input  logic               i_aline_done,
  output logic               o_aline_start,
  output logic [ALINE_W-1:0] o_aline_idx,
  output logic [BSCAN_W-1:0] o_bscan_idx,
  output logic               o_busy,
  output logic               o_vol_recording_done,
  output logic               o_missed_trig,
  output logic [MISS_W-1:0]  o_missed_cnt
);

  vol_state_e         r_state, w_state_nxt;
  logic [ALINE_W-1:0] r_n_alines, w_n_alines_nxt;
  logic [BSCAN_W-1:0] r_n_bscans, w_n_bscans_nxt;
  logic [ALINE_W-1:0] r_aline_idx, w_aline_idx_nxt;
  logic [BSCAN_W-1:0] r_bscan_idx, w_bscan_idx_nxt;
  logic               r_aline_start, w_aline_start_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_missed, w_missed_nxt;
  logic [MISS_W-1:0]  r_missed_cnt, w_missed_cnt_nxt;
  logic               w_trig_rise;
  logic [ALINE_W-1:0] w_aline_last;
  logic [BSCAN_W-1:0] w_bscan_last;

  vol_recording_ctrl_rise_edge_det u_trig_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .i_sig   (i_aline_trig),
    .o_rise  (w_trig_rise)
  );

  // Only consulted in WRITE_LINE, where the latched counts are known to be non-zero.
  assign w_aline_last = r_n_alines - ALINE_W'(1);
  assign w_bscan_last = r_n_bscans - BSCAN_W'(1);

  always_comb begin
    w_state_nxt       = r_state;
    w_n_alines_nxt    = r_n_alines;
    w_n_bscans_nxt    = r_n_bscans;
    w_aline_idx_nxt   = r_aline_idx;
    w_bscan_idx_nxt   = r_bscan_idx;
    w_aline_start_nxt = 1'b0;
    w_missed_nxt      = r_missed;
    w_missed_cnt_nxt  = r_missed_cnt;

    if (i_abort) begin
      // Indices and miss counters are left as-is for post-mortem inspection.
      w_state_nxt = StIdle;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            w_n_alines_nxt   = i_n_alines;
            w_n_bscans_nxt   = i_n_bscans;
            w_aline_idx_nxt  = '0;
            w_bscan_idx_nxt  = '0;
            w_missed_nxt     = 1'b0;
            w_missed_cnt_nxt = '0;
            // An empty volume completes immediately without touching the line writer.
            if ((i_n_alines == '0) || (i_n_bscans == '0)) begin
              w_state_nxt = StDone;
            end else begin
              w_state_nxt = StWaitTrig;
            end
          end
        end
        StWaitTrig: begin
          if (w_trig_rise) begin
            w_aline_start_nxt = 1'b1;
            w_state_nxt       = StWriteLine;
          end
        end
        StWriteLine: begin
          // A new sweep while the previous line is still being stored is lost, even when it
          // coincides with aline_done.
          if (w_trig_rise) begin
            w_missed_nxt = 1'b1;
            if (r_missed_cnt != {MISS_W{1'b1}}) begin
              w_missed_cnt_nxt = r_missed_cnt + MISS_W'(1);
            end
          end
          if (i_aline_done) begin
            if (r_aline_idx == w_aline_last) begin
              w_aline_idx_nxt = '0;
              if (r_bscan_idx == w_bscan_last) begin
                w_state_nxt = StDone;
              end else begin
                w_bscan_idx_nxt = r_bscan_idx + BSCAN_W'(1);
                w_state_nxt     = StWaitTrig;
              end
            end else begin
              w_aline_idx_nxt = r_aline_idx + ALINE_W'(1);
              w_state_nxt     = StWaitTrig;
            end
          end
        end
        default: begin
          w_state_nxt = StIdle;
        end
      endcase
    end

    // Status outputs are registered copies of the next-state decode.
    w_busy_nxt = (w_state_nxt == StWaitTrig) || (w_state_nxt == StWriteLine);
    w_done_nxt = (w_state_nxt == StDone);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StIdle;
      r_n_alines    <= '0;
      r_n_bscans    <= '0;
      r_aline_idx   <= '0;
      r_bscan_idx   <= '0;
      r_aline_start <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_missed      <= 1'b0;
      r_missed_cnt  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_n_alines    <= w_n_alines_nxt;
      r_n_bscans    <= w_n_bscans_nxt;
      r_aline_idx   <= w_aline_idx_nxt;
      r_bscan_idx   <= w_bscan_idx_nxt;
      r_aline_start <= w_aline_start_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_missed      <= w_missed_nxt;
      r_missed_cnt  <= w_missed_cnt_nxt;
    end
  end

  assign o_aline_start        = r_aline_start;
  assign o_aline_idx          = r_aline_idx;
  assign o_bscan_idx          = r_bscan_idx;
  assign o_busy               = r_busy;
  assign o_vol_recording_done = r_done;
  assign o_missed_trig        = r_missed;
  assign o_missed_cnt         = r_missed_cnt;

endmodule
